// File: rtl/rvfi_dmem_window_check.sv
// Byte-granular shadow of a small data-memory window, checked against every retired load on RVFI.
// Reports the first load whose data disagrees with the last store (or first captured read).
module rvfi_dmem_window_check #(
  parameter int XLEN      = 32,
  parameter int NRET      = 1,
  parameter int NWORDS    = 4,
  parameter int CAPTURE   = 1,
  parameter int CNT_W     = 16,
  parameter int ASSERT_EN = 0,
  localparam int NB = XLEN / 8,
  localparam int BW = $clog2(NB),
  localparam int WW = (NWORDS > 1) ? $clog2(NWORDS) : 1,
  localparam int CW = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [XLEN-1:0]        dmem_base,
  input  logic [NRET-1:0]        rvfi_valid,
  input  logic [NRET-1:0]        rvfi_trap,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_addr,
  input  logic [NRET*NB-1:0]     rvfi_mem_rmask,
  input  logic [NRET*NB-1:0]     rvfi_mem_wmask,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_wdata,
  output logic                   err,
  output logic [CW-1:0]          err_chan,
  output logic [WW-1:0]          err_word,
  output logic [BW-1:0]          err_byte,
  output logic [7:0]             err_expected,
  output logic [7:0]             err_actual,
  output logic [CNT_W-1:0]       check_count
);

  localparam int SW = $clog2(NRET * NB + 1);
  localparam int TW = CNT_W + SW;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [7:0]    shadow_q [NWORDS][NB];
  logic [7:0]    shadow_d [NWORDS][NB];
  logic [NB-1:0] valid_q  [NWORDS];
  logic [NB-1:0] valid_d  [NWORDS];

  logic [NRET-1:0] hit;
  logic [WW-1:0]   idx [NRET];

  logic            mismatch;
  logic [CW-1:0]   m_chan;
  logic [WW-1:0]   m_word;
  logic [BW-1:0]   m_byte;
  logic [7:0]      m_exp;
  logic [7:0]      m_act;
  logic [SW-1:0]   cmp_sum;
  logic [TW-1:0]   cnt_tot;
  logic [CNT_W-1:0] cnt_d;

  // Window offset wraps modulo 2^XLEN, so addresses below the base land far out of range.
  always_comb begin : decode
    logic [XLEN-1:0] word;
    hit  = '0;
    word = '0;
    for (int c = 0; c < NRET; c++) begin
      word   = (rvfi_mem_addr[c*XLEN +: XLEN] - dmem_base) >> BW;
      hit[c] = rvfi_valid[c] & ~rvfi_trap[c] & (word < XLEN'(NWORDS));
      idx[c] = word[WW-1:0];
    end
  end

  always_comb begin : update
    logic [7:0]    rb;
    logic [7:0]    wb;
    logic [WW-1:0] ix;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    mismatch = 1'b0;
    m_chan   = '0;
    m_word   = '0;
    m_byte   = '0;
    m_exp    = '0;
    m_act    = '0;
    cmp_sum  = '0;
    rb       = '0;
    wb       = '0;
    ix       = '0;
    for (int c = 0; c < NRET; c++) begin
      if (hit[c]) begin
        ix = idx[c];
        for (int b = 0; b < NB; b++) begin
          rb = rvfi_mem_rdata[c*XLEN + 8*b +: 8];
          wb = rvfi_mem_wdata[c*XLEN + 8*b +: 8];
          // Read side first so an AMO compares the old value before its own write lands.
          if (rvfi_mem_rmask[c*NB + b]) begin
            if (valid_d[ix][b]) begin
              cmp_sum = cmp_sum + SW'(1);
              if (!mismatch && (shadow_d[ix][b] != rb)) begin
                mismatch = 1'b1;
                m_chan   = CW'(c);
                m_word   = ix;
                m_byte   = BW'(b);
                m_exp    = shadow_d[ix][b];
                m_act    = rb;
              end
            end else if (CAPTURE != 0) begin
              shadow_d[ix][b] = rb;
              valid_d[ix][b]  = 1'b1;
            end
          end
          if (rvfi_mem_wmask[c*NB + b]) begin
            shadow_d[ix][b] = wb;
            valid_d[ix][b]  = 1'b1;
          end
        end
      end
    end
  end

  assign cnt_tot = TW'(check_count) + TW'(cmp_sum);
  assign cnt_d   = (cnt_tot > TW'(CNT_MAX)) ? CNT_MAX : cnt_tot[CNT_W-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int w = 0; w < NWORDS; w++) begin
        for (int b = 0; b < NB; b++) begin
          shadow_q[w][b] <= '0;
        end
        valid_q[w] <= '0;
      end
      err          <= 1'b0;
      err_chan     <= '0;
      err_word     <= '0;
      err_byte     <= '0;
      err_expected <= '0;
      err_actual   <= '0;
      check_count  <= '0;
    end else begin
      shadow_q    <= shadow_d;
      valid_q     <= valid_d;
      check_count <= cnt_d;
      if (!err && mismatch) begin
        err          <= 1'b1;
        err_chan     <= m_chan;
        err_word     <= m_word;
        err_byte     <= m_byte;
        err_expected <= m_exp;
        err_actual   <= m_act;
      end
    end
  end

  generate
    if (ASSERT_EN != 0) begin : g_assert
      always @(posedge clk) begin
        if (resetn) begin
          assert (!mismatch);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_rvfi_dmem_window_check.sv
// Bench for rvfi_dmem_window_check: three configurations (capture, no capture, 3-bit counter)
// share one stimulus stream and are compared against a byte-addressed memory model.
module tb_rvfi_dmem_window_check;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] dmem_base;
  logic [1:0]  rvfi_valid;
  logic [1:0]  rvfi_trap;
  logic [63:0] rvfi_mem_addr;
  logic [7:0]  rvfi_mem_rmask;
  logic [7:0]  rvfi_mem_wmask;
  logic [63:0] rvfi_mem_rdata;
  logic [63:0] rvfi_mem_wdata;

  logic [2:0]      err_o;
  logic [2:0]      chan_o;
  logic [2:0][1:0] word_o;
  logic [2:0][1:0] byte_o;
  logic [2:0][7:0] exp_o;
  logic [2:0][7:0] act_o;
  logic [15:0]     cnt_main;
  logic [15:0]     cnt_nocap;
  logic [2:0]      cnt_sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rvfi_dmem_window_check #(.XLEN(32), .NRET(2), .NWORDS(4), .CAPTURE(1), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .dmem_base(dmem_base),
    .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .err(err_o[0]), .err_chan(chan_o[0:0]), .err_word(word_o[0]), .err_byte(byte_o[0]),
    .err_expected(exp_o[0]), .err_actual(act_o[0]), .check_count(cnt_main));

  rvfi_dmem_window_check #(.XLEN(32), .NRET(2), .NWORDS(4), .CAPTURE(0), .CNT_W(16)) dut_nocap (
    .clk(clk), .resetn(resetn), .dmem_base(dmem_base),
    .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .err(err_o[1]), .err_chan(chan_o[1:1]), .err_word(word_o[1]), .err_byte(byte_o[1]),
    .err_expected(exp_o[1]), .err_actual(act_o[1]), .check_count(cnt_nocap));

  rvfi_dmem_window_check #(.XLEN(32), .NRET(2), .NWORDS(4), .CAPTURE(1), .CNT_W(3)) dut_sat (
    .clk(clk), .resetn(resetn), .dmem_base(dmem_base),
    .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .err(err_o[2]), .err_chan(chan_o[2:2]), .err_word(word_o[2]), .err_byte(byte_o[2]),
    .err_expected(exp_o[2]), .err_actual(act_o[2]), .check_count(cnt_sat));

  // Reference: a 16-byte memory per configuration, addressed by byte offset from the base.
  logic [7:0] md    [3][16];
  bit         mv    [3][16];
  bit         merr  [3];
  int         mchan [3];
  int         mword [3];
  int         mbyte [3];
  int         mexp  [3];
  int         mact  [3];
  int         mcnt  [3];
  int         cmax  [3] = '{65535, 65535, 7};
  bit         mcap  [3] = '{1'b1, 1'b0, 1'b1};

  function automatic logic [31:0] getCnt(input int k);
    case (k)
      0:       return 32'(cnt_main);
      1:       return 32'(cnt_nocap);
      default: return 32'(cnt_sat);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 16; a++) begin
        md[k][a] = 8'h00;
        mv[k][a] = 1'b0;
      end
      merr[k] = 1'b0; mchan[k] = 0; mword[k] = 0; mbyte[k] = 0;
      mexp[k] = 0; mact[k] = 0; mcnt[k] = 0;
    end
  endtask

  task automatic modelStep();
    logic [31:0] off;
    logic [7:0]  rb;
    logic [7:0]  wb;
    int          a;
    for (int k = 0; k < 3; k++) begin
      bit found = 1'b0;
      int cmps  = 0;
      int fc = 0, fw = 0, fb = 0, fe = 0, fa = 0;
      for (int c = 0; c < 2; c++) begin
        off = rvfi_mem_addr[c*32 +: 32] - dmem_base;
        if (rvfi_valid[c] && !rvfi_trap[c] && off < 32'd16) begin
          for (int b = 0; b < 4; b++) begin
            a  = int'(off >> 2) * 4 + b;
            rb = rvfi_mem_rdata[c*32 + 8*b +: 8];
            wb = rvfi_mem_wdata[c*32 + 8*b +: 8];
            if (rvfi_mem_rmask[c*4 + b]) begin
              if (mv[k][a]) begin
                cmps++;
                if (md[k][a] !== rb && !found) begin
                  found = 1'b1; fc = c; fw = a / 4; fb = b; fe = int'(md[k][a]); fa = int'(rb);
                end
              end else if (mcap[k]) begin
                md[k][a] = rb;
                mv[k][a] = 1'b1;
              end
            end
            if (rvfi_mem_wmask[c*4 + b]) begin
              md[k][a] = wb;
              mv[k][a] = 1'b1;
            end
          end
        end
      end
      if (found && !merr[k]) begin
        merr[k] = 1'b1; mchan[k] = fc; mword[k] = fw; mbyte[k] = fb; mexp[k] = fe; mact[k] = fa;
      end
      mcnt[k] = (mcnt[k] + cmps > cmax[k]) ? cmax[k] : mcnt[k] + cmps;
    end
  endtask

  task automatic checkAll();
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("k%0d.err", k),   32'(err_o[k]),  32'(merr[k]));
      checkOutput($sformatf("k%0d.chan", k),  32'(chan_o[k]), mchan[k]);
      checkOutput($sformatf("k%0d.word", k),  32'(word_o[k]), mword[k]);
      checkOutput($sformatf("k%0d.byte", k),  32'(byte_o[k]), mbyte[k]);
      checkOutput($sformatf("k%0d.exp", k),   32'(exp_o[k]),  mexp[k]);
      checkOutput($sformatf("k%0d.act", k),   32'(act_o[k]),  mact[k]);
      checkOutput($sformatf("k%0d.count", k), getCnt(k),      mcnt[k]);
    end
  endtask

  task automatic clearChans();
    rvfi_valid = '0; rvfi_trap = '0; rvfi_mem_addr = '0;
    rvfi_mem_rmask = '0; rvfi_mem_wmask = '0; rvfi_mem_rdata = '0; rvfi_mem_wdata = '0;
  endtask

  task automatic setChan(input int c, input logic [31:0] addr, input logic [3:0] rm,
                         input logic [3:0] wm, input logic [31:0] rd, input logic [31:0] wd,
                         input bit trap = 1'b0);
    rvfi_valid[c]               = 1'b1;
    rvfi_trap[c]                = trap;
    rvfi_mem_addr[c*32 +: 32]   = addr;
    rvfi_mem_rmask[c*4 +: 4]    = rm;
    rvfi_mem_wmask[c*4 +: 4]    = wm;
    rvfi_mem_rdata[c*32 +: 32]  = rd;
    rvfi_mem_wdata[c*32 +: 32]  = wd;
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
    clearChans();
  endtask

  // Reset lands mid-cycle so the clear is seen before any clock edge.
  task automatic doReset(input logic [31:0] base);
    #2;
    resetn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rst%0d.err", k), 32'(err_o[k]), 32'd0);
      checkOutput($sformatf("rst%0d.count", k), getCnt(k), 32'd0);
    end
    modelReset();
    dmem_base = base;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    checkAll();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] base;
    logic [31:0] addr;
    logic [31:0] rd;
    logic [31:0] off;
    int          a;
    resetn    = 1'b1;
    dmem_base = 32'h1000;
    clearChans();
    modelReset();
    doReset(32'h1000);

    // Write then matching read
    setChan(0, 32'h1004, 4'h0, 4'hF, 32'h0, 32'hDEADBEEF); applyStimulus();
    setChan(0, 32'h1004, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0); applyStimulus();
    checkOutput("t1.count", 32'(cnt_main), 32'd4);
    checkOutput("t1.err", 32'(err_o[0]), 32'd0);

    // Same-cycle forwarding from ch0 write to ch1 read, then a bad read
    doReset(32'h1000);
    setChan(0, 32'h1008, 4'h0, 4'hF, 32'h0, 32'h11223344);
    setChan(1, 32'h1008, 4'hF, 4'h0, 32'h11223344, 32'h0); applyStimulus();
    checkOutput("t2.count", 32'(cnt_main), 32'd4);
    setChan(1, 32'h1008, 4'hF, 4'h0, 32'h11223345, 32'h0); applyStimulus();
    checkOutput("t2.err", 32'(err_o[0]), 32'd1);
    checkOutput("t2.chan", 32'(chan_o[0]), 32'd1);
    checkOutput("t2.word", 32'(word_o[0]), 32'd2);
    checkOutput("t2.byte", 32'(byte_o[0]), 32'd0);
    checkOutput("t2.exp", 32'(exp_o[0]), 32'h44);
    checkOutput("t2.act", 32'(act_o[0]), 32'h45);

    // Capture on first read
    doReset(32'h1000);
    setChan(0, 32'h100C, 4'h3, 4'h0, 32'hAAAA5566, 32'h0); applyStimulus();
    checkOutput("t3.count", 32'(cnt_main), 32'd0);
    setChan(0, 32'h100C, 4'h3, 4'h0, 32'h00005567, 32'h0); applyStimulus();
    checkOutput("t3.exp", 32'(exp_o[0]), 32'h66);
    checkOutput("t3.nocap_err", 32'(err_o[1]), 32'd0);
    checkOutput("t3.nocap_count", 32'(cnt_nocap), 32'd0);

    // Out of window (above and wrapped below) and trapped writes
    doReset(32'h1000);
    setChan(0, 32'h1010, 4'h0, 4'hF, 32'h0, 32'h12345678);
    setChan(1, 32'h0FFC, 4'h0, 4'hF, 32'h0, 32'hCAFEF00D); applyStimulus();
    setChan(0, 32'h1010, 4'hF, 4'h0, 32'h0, 32'h0);
    setChan(1, 32'h0FFC, 4'hF, 4'h0, 32'h1, 32'h0); applyStimulus();
    setChan(0, 32'h1000, 4'h0, 4'hF, 32'h0, 32'h55555555, 1'b1); applyStimulus();
    setChan(0, 32'h1000, 4'hF, 4'h0, 32'h0, 32'h0); applyStimulus();
    checkOutput("t4.count", 32'(cnt_main), 32'd0);
    checkOutput("t4.nocap_count", 32'(cnt_nocap), 32'd0);

    // Byte lanes and two simultaneous mismatches
    doReset(32'h1000);
    setChan(0, 32'h1000, 4'h0, 4'h4, 32'h0, 32'h00AB0000); applyStimulus();
    setChan(0, 32'h1000, 4'hF, 4'h0, 32'h12AB3456, 32'h0); applyStimulus();
    checkOutput("t5.count", 32'(cnt_main), 32'd1);
    setChan(0, 32'h1000, 4'h8, 4'h0, 32'hFF000000, 32'h0);
    setChan(1, 32'h1000, 4'h1, 4'h0, 32'h00000000, 32'h0); applyStimulus();
    checkOutput("t5.chan", 32'(chan_o[0]), 32'd0);
    checkOutput("t5.byte", 32'(byte_o[0]), 32'd3);

    // Saturation, then reset mid-stream
    doReset(32'h1000);
    setChan(0, 32'h1000, 4'h0, 4'hF, 32'h0, 32'h01020304);
    setChan(1, 32'h1004, 4'h0, 4'hF, 32'h0, 32'h05060708); applyStimulus();
    for (int i = 0; i < 3; i++) begin
      setChan(0, 32'h1000, 4'hF, 4'h0, 32'h01020304, 32'h0); applyStimulus();
    end
    checkOutput("t6.sat_count", 32'(cnt_sat), 32'd7);
    checkOutput("t6.count", 32'(cnt_main), 32'd12);
    setChan(0, 32'h1004, 4'hF, 4'h0, 32'h0, 32'h0); applyStimulus();
    doReset(32'h1000);
    setChan(0, 32'h1000, 4'hF, 4'h0, 32'h01020304, 32'h0); applyStimulus();
    checkOutput("t6.reread_count", 32'(cnt_main), 32'd0);

    // Randomised traffic around the window, including bases that wrap
    for (int r = 0; r < 6; r++) begin
      case (r % 4)
        0:       base = 32'h1000;
        1:       base = 32'h0;
        2:       base = 32'hFFFFFFF8;
        default: base = $urandom & 32'hFFFFFFFC;
      endcase
      doReset(base);
      for (int n = 0; n < 50; n++) begin
        for (int c = 0; c < 2; c++) begin
          if ($urandom_range(0, 3) != 0) begin
            addr = base + 32'($urandom_range(0, 31)) - 32'd8;
            off  = addr - base;
            rd   = $urandom;
            if (off < 32'd16) begin
              for (int b = 0; b < 4; b++) begin
                a = int'(off >> 2) * 4 + b;
                if (mv[0][a]) rd[8*b +: 8] = md[0][a];
              end
            end
            if ($urandom_range(0, 15) == 0) rd = rd ^ (32'd1 << $urandom_range(0, 31));
            setChan(c, addr, 4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                    rd, $urandom, ($urandom_range(0, 9) == 0));
          end
        end
        applyStimulus();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
